// File: rtl/hazard_unit.sv
// Hazard/forwarding control for the F/D/E/M/W pipeline: combinational stall, flush and forward selects
// from E/M/W shadow registers; stalls on data-memory wait, with a sticky watchdog flag.
module hazard_unit #(
  parameter int RA_W    = 4,
  parameter int PC_REG  = 15,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [RA_W-1:0] Ra1D,
  input  logic [RA_W-1:0] Ra2D,
  input  logic [RA_W-1:0] WA3D,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            MemReqD,
  input  logic            RegWriteEOut,
  input  logic            PCSrcEOut,
  input  logic            MemReadyM,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushW,
  output logic            MemTimeout
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic            RUN      = 1'b0;
  localparam logic            MEM_WAIT = 1'b1;
  localparam logic [RA_W-1:0] PC_IDX   = RA_W'(PC_REG);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);

  logic [RA_W-1:0] ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa3_e_q, wa3_e_d;
  logic            reg_write_e_q, reg_write_e_d, memto_reg_e_q, memto_reg_e_d;
  logic            mem_req_e_q, mem_req_e_d;
  logic [RA_W-1:0] wa3_m_q, wa3_m_d, wa3_w_q, wa3_w_d;
  logic            reg_write_m_q, reg_write_m_d, mem_req_m_q, mem_req_m_d;
  logic            reg_write_w_q, reg_write_w_d;
  logic            state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            first_q, first_d;

  logic memstall, ldrstall, active;

  // Outputs are held at zero during reset and for the one cycle after it.
  always_comb begin
    memstall = mem_req_m_q & ~MemReadyM;
    ldrstall = memto_reg_e_q & reg_write_e_q & ((wa3_e_q == Ra1D) | (wa3_e_q == Ra2D));
    active   = ~RESET & ~first_q;
    StallF     = active & ((ldrstall & ~PCSrcEOut) | memstall);
    StallD     = active & (ldrstall | memstall);
    StallE     = active & memstall;
    StallM     = active & memstall;
    FlushD     = active & PCSrcEOut & ~memstall;
    FlushE     = active & (ldrstall | PCSrcEOut) & ~memstall;
    FlushW     = active & memstall;
    MemTimeout = active & timeout_q;
  end

  // M has priority over W; the PC register is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (active) begin
      if (reg_write_m_q && wa3_m_q == ra1_e_q && ra1_e_q != PC_IDX)      ForwardAE = 2'b10;
      else if (reg_write_w_q && wa3_w_q == ra1_e_q && ra1_e_q != PC_IDX) ForwardAE = 2'b01;
      if (reg_write_m_q && wa3_m_q == ra2_e_q && ra2_e_q != PC_IDX)      ForwardBE = 2'b10;
      else if (reg_write_w_q && wa3_w_q == ra2_e_q && ra2_e_q != PC_IDX) ForwardBE = 2'b01;
    end
  end

  always_comb begin
    ra1_e_d       = ra1_e_q;
    ra2_e_d       = ra2_e_q;
    wa3_e_d       = wa3_e_q;
    reg_write_e_d = reg_write_e_q;
    memto_reg_e_d = memto_reg_e_q;
    mem_req_e_d   = mem_req_e_q;
    wa3_m_d       = wa3_m_q;
    reg_write_m_d = reg_write_m_q;
    mem_req_m_d   = mem_req_m_q;
    wa3_w_d       = wa3_w_q;
    reg_write_w_d = reg_write_w_q;
    if (memstall) begin
      reg_write_w_d = 1'b0;
    end else begin
      if (FlushE) begin
        ra1_e_d       = '0;
        ra2_e_d       = '0;
        wa3_e_d       = '0;
        reg_write_e_d = 1'b0;
        memto_reg_e_d = 1'b0;
        mem_req_e_d   = 1'b0;
      end else begin
        ra1_e_d       = Ra1D;
        ra2_e_d       = Ra2D;
        wa3_e_d       = WA3D;
        reg_write_e_d = RegWriteD;
        memto_reg_e_d = MemtoRegD;
        mem_req_e_d   = MemReqD;
      end
      // M takes the condition-qualified write, not the raw decode flag.
      wa3_m_d       = wa3_e_q;
      reg_write_m_d = RegWriteEOut;
      mem_req_m_d   = mem_req_e_q;
      wa3_w_d       = wa3_m_q;
      reg_write_w_d = reg_write_m_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    first_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = MEM_WAIT;
          cnt_d   = '0;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM)             state_d = RUN;
        else if (cnt_q != CNT_MAX) cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (state_d == MEM_WAIT && cnt_d == CNT_MAX) timeout_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ra1_e_q       <= '0;
      ra2_e_q       <= '0;
      wa3_e_q       <= '0;
      reg_write_e_q <= 1'b0;
      memto_reg_e_q <= 1'b0;
      mem_req_e_q   <= 1'b0;
      wa3_m_q       <= '0;
      reg_write_m_q <= 1'b0;
      mem_req_m_q   <= 1'b0;
      wa3_w_q       <= '0;
      reg_write_w_q <= 1'b0;
      state_q       <= RUN;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
      first_q       <= 1'b1;
    end else begin
      ra1_e_q       <= ra1_e_d;
      ra2_e_q       <= ra2_e_d;
      wa3_e_q       <= wa3_e_d;
      reg_write_e_q <= reg_write_e_d;
      memto_reg_e_q <= memto_reg_e_d;
      mem_req_e_q   <= mem_req_e_d;
      wa3_m_q       <= wa3_m_d;
      reg_write_m_q <= reg_write_m_d;
      mem_req_m_q   <= mem_req_m_d;
      wa3_w_q       <= wa3_w_d;
      reg_write_w_q <= reg_write_w_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
      first_q       <= first_d;
    end
  end

endmodule
